// File: rtl/m_sequencer_if.sv
// Handshake and control bundle between EX, the M-unit datapath and its sequencer.
// Also defines the MUX_*_LENGTH select widths used by the sequencer ports.
`ifndef M_SEQUENCER_MUX_WIDTHS
`define M_SEQUENCER_MUX_WIDTHS
`define MUX_MULTA_LENGTH 2
`define MUX_MULTB_LENGTH 2
`define MUX_R_LENGTH     3
`define MUX_D_LENGTH     2
`define MUX_Z_LENGTH     2
`endif

interface m_sequencer_if;
    logic                         start;
    logic [2:0]                   funct3;
    logic                         rs1_sign;
    logic                         rs2_sign;
    logic                         rs2_zero;
    logic                         flush;
    logic                         sub_neg;
    logic [`MUX_MULTA_LENGTH-1:0] mux_multA;
    logic [`MUX_MULTB_LENGTH-1:0] mux_multB;
    logic [`MUX_R_LENGTH-1:0]     mux_R;
    logic [`MUX_D_LENGTH-1:0]     mux_D;
    logic [`MUX_Z_LENGTH-1:0]     mux_Z;
    logic                         busy;
    logic                         done;
    logic                         res_sel;
    logic                         res_neg;
    logic                         res_ones;

    modport master (
        output start, funct3, rs1_sign, rs2_sign, rs2_zero, flush, sub_neg,
        input  mux_multA, mux_multB, mux_R, mux_D, mux_Z,
        input  busy, done, res_sel, res_neg, res_ones
    );

    modport slave (
        input  start, funct3, rs1_sign, rs2_sign, rs2_zero, flush, sub_neg,
        output mux_multA, mux_multB, mux_R, mux_D, mux_Z,
        output busy, done, res_sel, res_neg, res_ones
    );
endinterface

// File: rtl/m_sequencer.sv
// Sequencer FSM for the RV32M multiply/divide datapath: DSP multiply or 32-step restoring divide.
// Optional macro M_DIV0_FAST_EN: divide-by-zero skips the iterations and finishes one cycle after accept.
module m_sequencer #(
    parameter int MUL_LATENCY = 1
) (
    input  logic         clk,
    input  logic         resetn,
    m_sequencer_if.slave bus
);
    localparam logic [`MUX_R_LENGTH-1:0] R_KEEP     = 3'd0;
    localparam logic [`MUX_R_LENGTH-1:0] R_A        = 3'd1;
    localparam logic [`MUX_R_LENGTH-1:0] R_A_NEG    = 3'd2;
    localparam logic [`MUX_R_LENGTH-1:0] R_SUB_KEEP = 3'd3;
    localparam logic [`MUX_R_LENGTH-1:0] R_MULT_LO  = 3'd4;

    localparam logic [`MUX_D_LENGTH-1:0] D_KEEP  = 2'd0;
    localparam logic [`MUX_D_LENGTH-1:0] D_B     = 2'd1;
    localparam logic [`MUX_D_LENGTH-1:0] D_B_NEG = 2'd2;
    localparam logic [`MUX_D_LENGTH-1:0] D_SHR   = 2'd3;

    localparam logic [`MUX_Z_LENGTH-1:0] Z_KEEP    = 2'd0;
    localparam logic [`MUX_Z_LENGTH-1:0] Z_ZERO    = 2'd1;
    localparam logic [`MUX_Z_LENGTH-1:0] Z_SHL_ADD = 2'd2;
    localparam logic [`MUX_Z_LENGTH-1:0] Z_MULT_HI = 2'd3;

    localparam logic [1:0] M_ZERO     = 2'd0;
    localparam logic [1:0] M_UNSIGNED = 2'd1;
    localparam logic [1:0] M_SIGNED   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_MUL_OP, S_MUL_WAIT, S_MUL_WB, S_DIV_ITER, S_DONE
    } state_t;

    state_t     r_state, w_next;
    logic [4:0] r_cnt;
    logic [2:0] r_funct3;
    logic       r_rs1_sign, r_rs2_sign, r_rs2_zero, r_op_vld;

    logic       w_accept, w_in_div, w_in_sdiv, w_fast_div0;
    logic [1:0] w_multA_sel, w_multB_sel;

    assign w_accept  = (r_state == S_IDLE) && bus.start && !bus.flush;
    assign w_in_div  = bus.funct3[2];
    assign w_in_sdiv = bus.funct3[2] && !bus.funct3[0];

`ifdef M_DIV0_FAST_EN
    assign w_fast_div0 = bus.rs2_zero;
`else
    assign w_fast_div0 = 1'b0;
`endif

    // Operand sign handling comes from the latched op, so it stays stable across the whole multiply.
    assign w_multA_sel = (r_funct3 == 3'd1 || r_funct3 == 3'd2) ? M_SIGNED : M_UNSIGNED;
    assign w_multB_sel = (r_funct3 == 3'd1) ? M_SIGNED : M_UNSIGNED;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_funct3   <= 3'd0;
            r_rs1_sign <= 1'b0;
            r_rs2_sign <= 1'b0;
            r_rs2_zero <= 1'b0;
            r_op_vld   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3   <= bus.funct3;
                r_rs1_sign <= bus.rs1_sign;
                r_rs2_sign <= bus.rs2_sign;
                r_rs2_zero <= bus.rs2_zero;
                r_op_vld   <= 1'b1;
                r_cnt      <= 5'd0;
            end else if (r_state == S_DIV_ITER || r_state == S_MUL_WAIT) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.mux_R     = R_KEEP;
        bus.mux_D     = D_KEEP;
        bus.mux_Z     = Z_KEEP;
        bus.mux_multA = M_ZERO;
        bus.mux_multB = M_ZERO;
        bus.done      = 1'b0;
        if (bus.flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        bus.mux_Z = Z_ZERO;
                        bus.mux_R = (w_in_sdiv && bus.rs1_sign) ? R_A_NEG : R_A;
                        bus.mux_D = (w_in_sdiv && bus.rs2_sign) ? D_B_NEG : D_B;
                        if (!w_in_div)       w_next = S_MUL_OP;
                        else if (w_fast_div0) w_next = S_DONE;
                        else                 w_next = S_DIV_ITER;
                    end
                end
                S_MUL_OP: begin
                    bus.mux_multA = w_multA_sel;
                    bus.mux_multB = w_multB_sel;
                    w_next        = S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    bus.mux_multA = w_multA_sel;
                    bus.mux_multB = w_multB_sel;
                    if (r_cnt == 5'(MUL_LATENCY - 1)) w_next = S_MUL_WB;
                end
                S_MUL_WB: begin
                    bus.mux_multA = w_multA_sel;
                    bus.mux_multB = w_multB_sel;
                    bus.mux_R     = R_MULT_LO;
                    bus.mux_Z     = Z_MULT_HI;
                    w_next        = S_DONE;
                end
                S_DIV_ITER: begin
                    bus.mux_R = R_SUB_KEEP;
                    bus.mux_Z = Z_SHL_ADD;
                    bus.mux_D = D_SHR;
                    if (r_cnt == 5'd31) w_next = S_DONE;
                end
                S_DONE: begin
                    bus.done = 1'b1;
                    w_next   = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    // MUL keeps its low word in R; remainders live in R; everything else is read from Z.
    assign bus.res_sel = r_op_vld && (r_funct3 == 3'd0 || r_funct3[2:1] == 2'b11);
    assign bus.res_neg = r_op_vld && (((r_funct3 == 3'd4) && (r_rs1_sign ^ r_rs2_sign) && !r_rs2_zero)
                                     || ((r_funct3 == 3'd6) && r_rs1_sign));
`ifdef M_DIV0_FAST_EN
    assign bus.res_ones = r_op_vld && (r_funct3[2:1] == 2'b10) && r_rs2_zero;
`else
    assign bus.res_ones = 1'b0;
`endif
endmodule
